// File: rtl/seg_scan_mux_if.sv
// Bus between the display controller and the segment scan multiplexer:
// six digit patterns and controls in, multiplexed segment/digit drive out.
`timescale 1ns/1ps
interface seg_scan_mux_if;
   logic [6:0] in_sec_ge_seg;
   logic [6:0] in_sec_shi_seg;
   logic [6:0] in_min_ge_seg;
   logic [6:0] in_min_shi_seg;
   logic [6:0] in_hour_ge_seg;
   logic [6:0] in_hour_shi_seg;
   logic [5:0] dig_en;
   logic       blank_lz;
   logic [6:0] seg_out;
   logic [5:0] dig_sel;
   logic       frame_done;

   modport master (
      output in_sec_ge_seg, in_sec_shi_seg, in_min_ge_seg,
             in_min_shi_seg, in_hour_ge_seg, in_hour_shi_seg,
             dig_en, blank_lz,
      input  seg_out, dig_sel, frame_done
   );

   modport slave (
      input  in_sec_ge_seg, in_sec_shi_seg, in_min_ge_seg,
             in_min_shi_seg, in_hour_ge_seg, in_hour_shi_seg,
             dig_en, blank_lz,
      output seg_out, dig_sel, frame_done
   );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 6-digit 7-segment driver with per-slot blanking,
// leading-zero suppression and a per-frame input snapshot.
`timescale 1ns/1ps
module seg_scan_mux #(
   parameter int         DIV      = 50000,
   parameter int         BLANK    = 1000,
   parameter logic [6:0] ZERO_PAT = 7'b0111111
) (
   input  logic         clk,
   input  logic         rst,
   seg_scan_mux_if.slave bus
);
   localparam int              CW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]   CNT_MAX   = CW'(DIV - 1);
   localparam logic [CW-1:0]   BLANK_C   = CW'(BLANK);
   localparam logic [2:0]      LAST_SLOT = 3'd5;

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        slot_q, slot_d;
   logic [5:0][6:0]   pat_q, pat_d;
   logic [5:0]        en_q, en_d;
   logic              lz_q, lz_d;
   logic [6:0]        seg_q, seg_d;
   logic [5:0]        sel_q, sel_d;
   logic              fd_q, fd_d;
   logic              shown;

   // Outputs are a function of the next state and the next snapshot, so the
   // freshly captured frame is already visible on the edge that loads it.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      slot_d = slot_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d  = '0;
         slot_d = (slot_q == LAST_SLOT) ? 3'd0 : slot_q + 3'd1;
      end

      pat_d = pat_q;
      en_d  = en_q;
      lz_d  = lz_q;
      if (cnt_q == '0 && slot_q == 3'd0) begin
         pat_d = {bus.in_hour_shi_seg, bus.in_hour_ge_seg, bus.in_min_shi_seg,
                  bus.in_min_ge_seg, bus.in_sec_shi_seg, bus.in_sec_ge_seg};
         en_d  = bus.dig_en;
         lz_d  = bus.blank_lz;
      end

      shown = (cnt_d >= BLANK_C) && en_d[slot_d] &&
              !(slot_d == LAST_SLOT && lz_d && pat_d[5] == ZERO_PAT);
      seg_d = shown ? pat_d[slot_d] : 7'd0;
      sel_d = shown ? (6'b000001 << slot_d) : 6'd0;
      fd_d  = (cnt_q == CNT_MAX) && (slot_q == LAST_SLOT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         slot_q <= 3'd0;
         pat_q  <= '0;
         en_q   <= 6'd0;
         lz_q   <= 1'b0;
         seg_q  <= 7'd0;
         sel_q  <= 6'd0;
         fd_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         slot_q <= slot_d;
         pat_q  <= pat_d;
         en_q   <= en_d;
         lz_q   <= lz_d;
         seg_q  <= seg_d;
         sel_q  <= sel_d;
         fd_q   <= fd_d;
      end
   end

   assign bus.seg_out    = seg_q;
   assign bus.dig_sel    = sel_q;
   assign bus.frame_done = fd_q;
endmodule
